// File: rtl/led_seq_pkg.sv
// Shared types and sizing helpers for the LED count sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic BTN_RELEASED        = 1'b1;
  localparam int   PRESCALE_DIV_DEF    = 12000000;
  localparam int   DEBOUNCE_CYCLES_DEF = 240000;

  function automatic int presc_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  function automatic int deb_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/led_count_sequencer_if.sv
// Button pins and LED-side outputs of the sequencer, grouped as one bundle.
interface led_count_sequencer_if #(
  parameter int CNT_W = 3
);
  logic             btn_run_n;
  logic             btn_step_n;
  logic             btn_dir_n;
  logic [CNT_W-1:0] led;
  logic             running;
  logic             count_up;

  modport master (
    output btn_run_n, btn_step_n, btn_dir_n,
    input  led, running, count_up
  );

  modport slave (
    input  btn_run_n, btn_step_n, btn_dir_n,
    output led, running, count_up
  );
endinterface

// File: rtl/led_count_sequencer_btn_debounce.sv
// Raw active-low button -> 2-flop synchronizer -> debounce counter -> 1-cycle press pulse.
module btn_debounce
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  output logic press
);
  localparam int DW = deb_width(DEBOUNCE_CYCLES);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= BTN_RELEASED;
      sync_b <= BTN_RELEASED;
      level  <= BTN_RELEASED;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= pin_n;
      sync_b <= sync_a;
      press  <= 1'b0;
      // cnt holds how many consecutive samples so far disagree with the accepted level
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_b;
        cnt   <= '0;
        press <= (sync_b != BTN_RELEASED);
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end
endmodule

// File: rtl/led_count_sequencer.sv
// Run/pause/step/direction sequencer for the LED counter, single clock, enable-driven.
// Optional LIMIT_STOP_EN: saturate at the ends and drop out of RUN on reaching the limit.
module led_count_sequencer
  import led_seq_pkg::*;
#(
  parameter int CNT_W           = 3,
  parameter int PRESCALE_DIV    = PRESCALE_DIV_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
  input logic                  clk_in,
  input logic                  rst_in,
  led_count_sequencer_if.slave bus
);
  localparam int PW = presc_width(PRESCALE_DIV);

  state_t           state, state_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic [CNT_W-1:0] led_q, led_nxt;
  logic             up_q, up_nxt, run_q;
  logic             run_press, step_press, dir_press;
  logic             tick, step_en, hit_limit;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(clk_in), .rst(rst_in), .pin_n(bus.btn_run_n), .press(run_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk_in), .rst(rst_in), .pin_n(bus.btn_step_n), .press(step_press));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
    .clk(clk_in), .rst(rst_in), .pin_n(bus.btn_dir_n), .press(dir_press));

`ifdef LIMIT_STOP_EN
  function automatic logic at_limit(input logic [CNT_W-1:0] cur, input logic up);
    return up ? (cur == '1) : (cur == '0);
  endfunction
`endif

  function automatic logic [CNT_W-1:0] step_value(input logic [CNT_W-1:0] cur, input logic up);
`ifdef LIMIT_STOP_EN
    if (at_limit(cur, up)) return cur;
`endif
    return up ? cur + CNT_W'(1) : cur - CNT_W'(1);
  endfunction

  // A dir press lands in the same cycle as any step, so steps use the toggled direction
  assign up_nxt = up_q ^ dir_press;
  assign tick   = (state == RUN) && (presc == PW'(PRESCALE_DIV - 1));

  // Stage: state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      run_q <= 1'b0;
      presc <= '0;
      led_q <= '0;
      up_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      run_q <= (state_nxt == RUN);
      presc <= presc_nxt;
      led_q <= led_nxt;
      up_q  <= up_nxt;
    end
  end

  // Stage: next-state decode; run press outranks step press everywhere
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run_press) state_nxt = RUN;
               else if (step_press) state_nxt = PAUSE;
      RUN:     if (run_press || hit_limit) state_nxt = PAUSE;
      PAUSE:   if (run_press) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage: step qualification, count and prescaler updates
  always_comb begin
    step_en = 1'b0;
    case (state)
      RUN:     step_en = tick;
      default: step_en = step_press && !run_press;
    endcase
    led_nxt   = step_en ? step_value(led_q, up_nxt) : led_q;
    hit_limit = 1'b0;
`ifdef LIMIT_STOP_EN
    hit_limit = tick && at_limit(led_nxt, up_nxt);
`endif
    presc_nxt = '0;
    if (state == RUN && state_nxt == RUN && !tick) presc_nxt = presc + PW'(1);
  end

  assign bus.led      = led_q;
  assign bus.running  = run_q;
  assign bus.count_up = up_q;
endmodule
